// File: rtl/gate_vector_checker_pkg.sv
// Shared types and constants for the gate vector checker: gate_sel encoding,
// checker FSM states and the number of exhaustive two-input test vectors.
package gate_chk_pkg;

  localparam int NUM_VECTORS = 4;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NOT  = 3'd2,
    GATE_XOR  = 3'd3,
    GATE_NAND = 3'd4,
    GATE_NOR  = 3'd5,
    GATE_XNOR = 3'd6,
    GATE_RSVD = 3'd7
  } gate_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gate_vector_checker_ref_model.sv
// Combinational golden model of the gate under test; NOT looks only at A,
// and the reserved encoding yields 0 (never compared).
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);

  always_comb begin
    y_exp = 1'b0;
    case (sel)
      GATE_AND:  y_exp = a & b;
      GATE_OR:   y_exp = a | b;
      GATE_NOT:  y_exp = ~a;
      GATE_XOR:  y_exp = a ^ b;
      GATE_NAND: y_exp = ~(a & b);
      GATE_NOR:  y_exp = ~(a | b);
      GATE_XNOR: y_exp = ~(a ^ b);
      default:   y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Drives the four A/B vectors into an external gate, samples Y at the end of
// each hold window and reports pass/fail. Option: GATE_CHK_STOP_ON_FAIL_EN.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a_o,
  output logic       b_o,
  input  logic       y_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count,
  output logic       bad_sel
);

  state_e     state;
  logic [2:0] sel_q;
  logic [1:0] vec_idx;
  logic [3:0] hold_cnt;
  logic       y_exp;
  logic       mismatch;
  logic [2:0] err_nxt;
  logic       last_hold;
  logic       stop_run;

  // a_o/b_o always hold the current vector during DRIVE, so they feed the model
  gate_ref_model u_ref (
    .sel   (sel_q),
    .a     (a_o),
    .b     (b_o),
    .y_exp (y_exp)
  );

  always_comb begin
    // X/Z on y_i fails the equality test and therefore counts as a mismatch
    mismatch = 1'b1;
    if (y_i == y_exp) mismatch = 1'b0;
    err_nxt   = err_count + {2'b00, mismatch};
    last_hold = (hold_cnt == 4'(HOLD_CYCLES - 1));
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    stop_run  = (vec_idx == 2'(NUM_VECTORS - 1)) || mismatch;
`else
    stop_run  = (vec_idx == 2'(NUM_VECTORS - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= 3'd0;
      vec_idx   <= 2'd0;
      hold_cnt  <= 4'd0;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_vec  <= 4'd0;
      err_count <= 3'd0;
      bad_sel   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sel_q     <= gate_sel;
            pass      <= 1'b0;
            fail_vec  <= 4'd0;
            err_count <= 3'd0;
            vec_idx   <= 2'd0;
            hold_cnt  <= 4'd0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            busy      <= 1'b1;
            if (gate_sel == GATE_RSVD) begin
              bad_sel <= 1'b1;
              done    <= 1'b1;
              state   <= ST_DONE;
            end else begin
              bad_sel <= 1'b0;
              state   <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (last_hold) begin
            if (mismatch) begin
              fail_vec[vec_idx] <= 1'b1;
              err_count         <= err_nxt;
            end
            if (stop_run) begin
              state <= ST_DONE;
              done  <= 1'b1;
              a_o   <= 1'b0;
              b_o   <= 1'b0;
              pass  <= (err_nxt == 3'd0);
            end else begin
              vec_idx    <= vec_idx + 2'd1;
              hold_cnt   <= 4'd0;
              {a_o, b_o} <= vec_idx + 2'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker (HOLD_CYCLES=2) with a behavioural
// gate driving y_i from a_o/b_o, plus an optional per-vector override.
module tb_gate_vector_checker;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] gate_sel;
  logic       a_o, b_o, y_i;
  logic       busy, done, pass, bad_sel;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  logic [2:0] model_sel;
  logic       ovr_en;
  logic [1:0] ovr_vec;
  logic       ovr_val;

  int n_tests = 0;
  int n_fail  = 0;

  gate_vector_checker #(.HOLD_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gate_sel  (gate_sel),
    .a_o       (a_o),
    .b_o       (b_o),
    .y_i       (y_i),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_vec  (fail_vec),
    .err_count (err_count),
    .bad_sel   (bad_sel)
  );

  always #5 clk = ~clk;

  // Truth tables indexed by {a,b}
  function automatic logic gate_tt(input logic [2:0] s, input logic a, input logic b);
    logic [3:0] tt;
    case (s)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0011;
      3'd3:    tt = 4'b0110;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    return tt[{a, b}];
  endfunction

  always_comb begin
    y_i = gate_tt(model_sel, a_o, b_o);
    if (ovr_en && ({a_o, b_o} == ovr_vec)) y_i = ovr_val;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepting edge is edge 0; returns in cycle 1
  task automatic start_run(input logic [2:0] s, input logic keep);
    gate_sel = s;
    start    = 1'b1;
    step();
    if (!keep) start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = -1;
    for (int c = c0; c < c0 + 40; c++) begin
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gate_sel = 3'd0;
    model_sel = 3'd0; ovr_en = 1'b0; ovr_vec = 2'd0; ovr_val = 1'b0;
    step(); step();
    n_tests++;
    if ({a_o, b_o, busy, done, pass, bad_sel, fail_vec, err_count} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required 0", {a_o, b_o, busy, done, pass, bad_sel, fail_vec, err_count});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_and_pass();
    logic [1:0] k;
    logic [3:0] exp_ctl;
    model_sel = 3'd0;
    start_run(3'd0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      k = 2'((c - 1) / 2);
      exp_ctl = (c == 9) ? 4'b0011 : {k[1], k[0], 2'b10};
      n_tests++;
      if ({a_o, b_o, busy, done} !== exp_ctl) begin
        n_fail++;
        $display("FAIL and_seq cycle %0d: a,b,busy,done=%b required %b", c, {a_o, b_o, busy, done}, exp_ctl);
      end
      if (c < 9) step();
    end
    n_tests++;
    if ({pass, err_count, fail_vec, bad_sel} !== {1'b1, 3'd0, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL and_result: pass,err,fail_vec,bad=%b required 1_000_0000_0", {pass, err_count, fail_vec, bad_sel});
    end
    step();
    n_tests++;
    if ({busy, done, pass} !== 3'b001) begin
      n_fail++;
      $display("FAIL and_after_done: busy,done,pass=%b required 001", {busy, done, pass});
    end
  endtask

  task automatic test_nand_fault();
    int cyc;
    model_sel = 3'd0;
    start_run(3'd4, 1'b0);
    wait_done(1, cyc);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    n_tests++;
    if (cyc != 3) begin n_fail++; $display("FAIL nand_done_cycle: got %0d required 3", cyc); end
    n_tests++;
    if ({fail_vec, err_count, pass} !== {4'b0001, 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL nand_result: fail_vec,err,pass=%b required 0001_001_0", {fail_vec, err_count, pass});
    end
`else
    n_tests++;
    if (cyc != 9) begin n_fail++; $display("FAIL nand_done_cycle: got %0d required 9", cyc); end
    n_tests++;
    if ({fail_vec, err_count, pass} !== {4'b1111, 3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL nand_result: fail_vec,err,pass=%b required 1111_100_0", {fail_vec, err_count, pass});
    end
`endif
    step(); step();
  endtask

  task automatic test_xor_vec2();
    int cyc;
    model_sel = 3'd3; ovr_en = 1'b1; ovr_vec = 2'd2; ovr_val = 1'b0;
    start_run(3'd3, 1'b0);
    wait_done(1, cyc);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    n_tests++;
    if (cyc != 7) begin n_fail++; $display("FAIL xor_done_cycle: got %0d required 7", cyc); end
`else
    n_tests++;
    if (cyc != 9) begin n_fail++; $display("FAIL xor_done_cycle: got %0d required 9", cyc); end
`endif
    n_tests++;
    if ({fail_vec, err_count, pass} !== {4'b0100, 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL xor_result: fail_vec,err,pass=%b required 0100_001_0", {fail_vec, err_count, pass});
    end
    ovr_en = 1'b0;
    step(); step();
  endtask

  task automatic test_reserved();
    model_sel = 3'd0;
    start_run(3'd7, 1'b0);
    n_tests++;
    if ({done, busy, bad_sel, pass, a_o, b_o, fail_vec, err_count} !== {6'b111000, 4'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL rsvd_cycle1: done,busy,bad,pass,a,b,fv,err=%b required 111000_0000_000", {done, busy, bad_sel, pass, a_o, b_o, fail_vec, err_count});
    end
    step();
    n_tests++;
    if ({done, busy, bad_sel, pass, a_o, b_o} !== 6'b001000) begin
      n_fail++;
      $display("FAIL rsvd_cycle2: done,busy,bad,pass,a,b=%b required 001000", {done, busy, bad_sel, pass, a_o, b_o});
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic seen;
    model_sel = 3'd0;
    start_run(3'd0, 1'b0);
    step(); step(); step();
    rst = 1'b1; start = 1'b1; gate_sel = 3'd0;
    step();
    n_tests++;
    if ({busy, done, a_o, b_o, pass, bad_sel, fail_vec, err_count} !== 13'd0) begin
      n_fail++;
      $display("FAIL midrst_state: got %b required 0", {busy, done, a_o, b_o, pass, bad_sel, fail_vec, err_count});
    end
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: activity seen=%b required 0", seen); end
    model_sel = 3'd2;
    start_run(3'd2, 1'b0);
    wait_done(1, cyc);
    n_tests++;
    if (cyc != 9 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL not_after_rst: done cycle %0d pass %b required 9 and 1", cyc, pass);
    end
    step(); step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    model_sel = 3'd1;
    start_run(3'd1, 1'b1);
    step(); step();
    gate_sel = 3'd5;
    wait_done(3, cyc);
    n_tests++;
    if (cyc != 9 || pass !== 1'b1 || err_count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_first: done cycle %0d pass %b err %0d required 9, 1, 0", cyc, pass, err_count);
    end
    model_sel = 3'd5;
    step();
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy,done=%b required 00", {busy, done});
    end
    step();
    n_tests++;
    if ({busy, done, pass, a_o, b_o} !== 5'b10000) begin
      n_fail++;
      $display("FAIL b2b_second_accept: busy,done,pass,a,b=%b required 10000", {busy, done, pass, a_o, b_o});
    end
    start = 1'b0;
    wait_done(11, cyc);
    n_tests++;
    if (cyc != 19 || pass !== 1'b1 || fail_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_second: done cycle %0d pass %b fail_vec %b required 19, 1, 0000", cyc, pass, fail_vec);
    end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_and_pass();
    test_nand_fault();
    test_xor_vec2();
    test_reserved();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2, range 1..15: cycles each test vector is held before Y is sampled.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have port gate_sel  input  3  gate under test: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 reserved.
REQ-006 SHALL have ports a_o and b_o  output  1 each  stimulus to the gate-under-test A and B inputs.
REQ-007 SHALL have port y_i  input  1  gate-under-test output Y.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port pass  output  1  result: every sampled vector matched.
REQ-011 SHALL have port fail_vec  output  4  bit k set when vector k mismatched.
REQ-012 SHALL have port err_count  output  3  number of mismatches, 0..4.
REQ-013 SHALL have port bad_sel  output  1  last run requested reserved gate_sel.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, DONE; transitions IDLE->DRIVE on start with legal gate_sel, IDLE->DONE on start with gate_sel=7, DRIVE->DONE after vector 3 is sampled, DONE->IDLE unconditionally.
REQ-015 SHALL latch gate_sel on the accepting edge; later gate_sel changes SHALL NOT affect the run.
REQ-016 SHALL drive vector k (k=0..3) as a_o=k[1], b_o=k[0], for exactly HOLD_CYCLES cycles; a_o=b_o=0 outside DRIVE.
REQ-017 SHALL sample y_i on the edge ending the last hold cycle of each vector and compare with the expected value; NOT expects ~A, ignoring B.
REQ-018 SHALL assert done in the single cycle following edge E+4*HOLD_CYCLES, where E is the accepting edge (cycle E+1 for gate_sel=7).
REQ-019 SHALL clear pass, fail_vec, err_count, bad_sel on the accepting edge; all SHALL hold their final values from DONE until the next accepted start.
REQ-020 SHALL set pass=1 iff err_count==0 and bad_sel==0 at DONE; for gate_sel=7: bad_sel=1, pass=0, fail_vec=0, err_count=0.
REQ-021 SHALL ignore start while busy; a start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-022 SHALL treat y_i of X/Z as a mismatch.

Reset
REQ-023 SHALL on rst force state IDLE, vector index 0, hold counter 0, a_o=b_o=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, bad_sel=0.
REQ-024 SHALL, when rst asserts mid-run, abandon the run with no done pulse; rst takes priority over start in the same cycle.

Configuration
REQ-025 SHALL honour macro GATE_CHK_STOP_ON_FAIL_EN: when defined, the first mismatch moves DRIVE->DONE on the sampling edge, leaving later fail_vec bits 0; when undefined, all four vectors always run.

Structure
REQ-026 SHALL place the gate_sel encoding enum, FSM state enum, and constant NUM_VECTORS=4 in package gate_chk_pkg.
REQ-027 SHALL compute the expected value in combinational sub-module gate_ref_model (inputs sel, a, b; output y_exp).

Verification
REQ-028 SHALL cover: HOLD_CYCLES=2, gate_sel=0, bench models correct AND on y_i, start at edge 0 -> a_o/b_o sequence 00,01,10,11 two cycles each, done in cycle 9, pass=1, err_count=0, fail_vec=0000.
REQ-029 SHALL cover: gate_sel=4 with bench driving AND instead of NAND -> fail_vec=1111, err_count=4, pass=0; with GATE_CHK_STOP_ON_FAIL_EN defined -> fail_vec=0001, err_count=1, done in cycle 3.
REQ-030 SHALL cover: gate_sel=3, y_i forced 0 only on vector 2 -> fail_vec=0100, err_count=1, pass=0.
REQ-031 SHALL cover: gate_sel=7 -> done in cycle 1, bad_sel=1, pass=0, a_o=b_o=0 throughout.
REQ-032 SHALL cover: rst asserted in cycle 4 of a run -> next cycle busy=0, all outputs 0, no done; subsequent start with gate_sel=2 and correct NOT -> pass=1.
REQ-033 SHALL cover: start held high continuously and gate_sel changed mid-run -> first run uses latched value, second run accepted in the cycle after done, back-to-back.
